// File: rtl/continuous_monitoring_sys_if.sv
// Trace packet stream from the commit monitor to the downstream FIFO/DMA.
interface continuous_monitoring_sys_if #(
    parameter int AXI_DATA_WIDTH = 1024
) ();
    logic                      tvalid;
    logic                      tready;
    logic [AXI_DATA_WIDTH-1:0] tdata;
    logic                      tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/continuous_monitoring_sys.sv
// Commit-trace monitor: packs each new committed instruction with a timestamp and
// per-event counts into one stream word; start/end PC triggers gate tracing.
module continuous_monitoring_sys #(
    parameter int XLEN                                = 64,
    parameter int AXI_DATA_WIDTH                      = 1024,
    parameter int NUM_EVENTS                          = 115,
    parameter int EVENT_COUNTER_WIDTH                 = 7,
    parameter bit CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               i_instr,
    input  logic [XLEN-1:0]           i_pc,
    input  logic                      i_pc_valid,
    input  logic [NUM_EVENTS-1:0]     i_performance_events,
    input  logic                      i_en,
    input  logic [7:0]                i_ctrl_addr,
    input  logic [63:0]               i_ctrl_wdata,
    input  logic                      i_ctrl_write_enable,
    input  logic [31:0]               i_tlast_interval,
    continuous_monitoring_sys_if.master m_axis
);
    localparam int          CW       = EVENT_COUNTER_WIDTH;
    localparam int          CNT_BITS = NUM_EVENTS * CW;
    localparam int          PC_LO    = CNT_BITS;
    localparam int          CYC_LO   = PC_LO + XLEN;
    localparam int          INS_LO   = CYC_LO + 64;
    localparam logic [31:0] WFI      = 32'h10500073;

    logic                      r_we_d;
    logic                      r_start_en;
    logic                      r_end_en;
    logic [XLEN-1:0]           r_start_addr;
    logic [XLEN-1:0]           r_end_addr;
    logic                      r_tracing;
    logic                      r_first;
    logic [XLEN-1:0]           r_last_pc;
    logic [CNT_BITS-1:0]       r_cnt;
    logic [63:0]               r_cyc;
    logic [31:0]               r_item;
    logic                      r_tvalid;
    logic                      r_tlast;
    logic [AXI_DATA_WIDTH-1:0] r_tdata;

    logic                      w_wr;
    logic                      w_start_hit;
    logic                      w_end_hit;
    logic                      w_new;
    logic                      w_cap_req;
    logic                      w_accept;
    logic                      w_cap;
    logic [31:0]               w_idx;
    logic                      w_tlast_new;
    logic [CNT_BITS-1:0]       w_sum;
    logic [CNT_BITS-1:0]       w_cnt_next;
    logic [AXI_DATA_WIDTH-1:0] w_pkt;

    assign w_wr        = CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED ? (i_ctrl_write_enable && !r_we_d)
                                                             : i_ctrl_write_enable;
    assign w_start_hit = r_start_en && i_pc_valid && (i_pc == r_start_addr);
    assign w_end_hit   = r_end_en && i_pc_valid && (i_pc == r_end_addr);
    assign w_new       = i_pc_valid && (r_first || (i_pc != r_last_pc));
    assign w_cap_req   = i_en && (r_tracing || w_start_hit) && w_new && (i_instr != WFI);
    assign w_accept    = r_tvalid && m_axis.tready;
    assign w_cap       = w_cap_req && (!r_tvalid || m_axis.tready);

    // A packet loaded while the current one is accepted is the next item in the burst.
    assign w_idx       = w_accept ? (r_tlast ? 32'd0 : r_item + 32'd1) : r_item;
    assign w_tlast_new = (i_tlast_interval <= 32'd1) || (w_idx == i_tlast_interval - 32'd1);

    always_comb begin
        logic [CW-1:0] v_c;
        v_c        = '0;
        w_sum      = '0;
        w_cnt_next = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            v_c = r_cnt[i*CW +: CW];
            w_sum[i*CW +: CW] = (i_en && i_performance_events[i] && (v_c != '1)) ? v_c + 1'b1 : v_c;
            w_cnt_next[i*CW +: CW] = w_cap ? CW'(i_performance_events[i]) : w_sum[i*CW +: CW];
        end
        w_pkt                  = '0;
        w_pkt[CNT_BITS-1:0]    = w_sum;
        w_pkt[PC_LO +: XLEN]   = i_pc;
        w_pkt[CYC_LO +: 64]    = r_cyc;
        w_pkt[INS_LO +: 32]    = i_instr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we_d       <= 1'b0;
            r_start_en   <= 1'b0;
            r_end_en     <= 1'b0;
            r_start_addr <= '0;
            r_end_addr   <= '0;
            r_tracing    <= 1'b1;
            r_first      <= 1'b1;
            r_last_pc    <= '0;
            r_cnt        <= '0;
            r_cyc        <= '0;
        end else begin
            r_we_d <= i_ctrl_write_enable;
            r_cyc  <= r_cyc + 64'd1;
            r_cnt  <= w_cnt_next;
            if (w_wr) begin
                case (i_ctrl_addr)
                    8'd0:    r_start_en   <= i_ctrl_wdata[0];
                    8'd1:    r_end_en     <= i_ctrl_wdata[0];
                    8'd2:    r_start_addr <= i_ctrl_wdata[XLEN-1:0];
                    8'd3:    r_end_addr   <= i_ctrl_wdata[XLEN-1:0];
                    default: ;
                endcase
            end
            if (i_pc_valid) begin
                r_last_pc <= i_pc;
                r_first   <= 1'b0;
            end
            // Later assignments win: the end trigger still emits its own packet first.
            if (w_wr && (i_ctrl_addr == 8'd0) && i_ctrl_wdata[0])
                r_tracing <= 1'b0;
            if (w_start_hit)
                r_tracing <= 1'b1;
            if (w_end_hit)
                r_tracing <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
            r_item   <= '0;
        end else begin
            if (w_accept)
                r_item <= r_tlast ? 32'd0 : r_item + 32'd1;
            if (w_cap) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_pkt;
                r_tlast  <= w_tlast_new;
            end else if (w_accept) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tlast  = r_tlast;
endmodule

// File: tb/tb_continuous_monitoring_sys.sv
// Directed bench for the commit-trace monitor; expected values are hand-computed.
module tb_continuous_monitoring_sys;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  instr;
    logic [63:0]  pc;
    logic         pc_valid;
    logic [114:0] ev;
    logic         en;
    logic [7:0]   ctrl_addr;
    logic [63:0]  ctrl_wdata;
    logic         ctrl_we;
    logic [31:0]  tlast_interval;

    int n_chk = 0;
    int n_err = 0;
    int n_beat = 0;
    longint unsigned tb_cyc = 0;
    longint unsigned cap_cyc = 0;

    continuous_monitoring_sys_if #(.AXI_DATA_WIDTH(1024)) axis ();

    continuous_monitoring_sys dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_instr              (instr),
        .i_pc                 (pc),
        .i_pc_valid           (pc_valid),
        .i_performance_events (ev),
        .i_en                 (en),
        .i_ctrl_addr          (ctrl_addr),
        .i_ctrl_wdata         (ctrl_wdata),
        .i_ctrl_write_enable  (ctrl_we),
        .i_tlast_interval     (tlast_interval),
        .m_axis               (axis)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        cap_cyc = tb_cyc;
        @(posedge clk);
        #1;
        tb_cyc = rst ? 64'd0 : tb_cyc + 64'd1;
    endtask

    task automatic commit(input logic [63:0] p, input logic [31:0] ins);
        pc_valid = 1'b1;
        pc       = p;
        instr    = ins;
        step();
    endtask

    task automatic ctrl_write(input logic [7:0] a, input logic [63:0] d);
        ctrl_addr  = a;
        ctrl_wdata = d;
        ctrl_we    = 1'b1;
        step();
        ctrl_we    = 1'b0;
        step();
    endtask

    task automatic chk_pkt(input string tag, input logic [63:0] p, input logic [31:0] ins);
        chk({tag, ".valid"}, 64'(axis.tvalid), 64'd1);
        chk({tag, ".pc"},    axis.tdata[868:805], p);
        chk({tag, ".instr"}, 64'(axis.tdata[964:933]), 64'(ins));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pc_valid = 1'b0; pc = '0; instr = '0; ev = '0;
        ctrl_addr = '0; ctrl_wdata = '0; ctrl_we = 1'b0; tlast_interval = 32'd100;
        axis.tready = 1'b1;
        step();
        step();
        chk("rst.tvalid", 64'(axis.tvalid), 64'd0);
        chk("rst.tlast",  64'(axis.tlast), 64'd0);
        chk("rst.tdata",  axis.tdata[868:805], 64'd0);

        rst = 1'b0;
        en  = 1'b1;
        // pc starts at 0, equal to the reset value of last_pc: first-valid flag must capture it
        for (int k = 0; k < 4; k++) begin
            commit(64'(4 * k), 32'h13 + 32'(k) * 32'h100);
            n_beat++;
            chk_pkt("step", 64'(4 * k), 32'h13 + 32'(k) * 32'h100);
            chk("step.cycle", axis.tdata[932:869], 64'(k));
            chk("step.ev0",   64'(axis.tdata[6:0]), 64'd0);
            chk("step.tlast", 64'(axis.tlast), 64'd0);
        end
        chk("pad", 64'(axis.tdata[1023:965]), 64'd0);

        ev[7:0] = 8'hAA;
        commit(64'h100, 32'h13);
        n_beat++;
        chk_pkt("hold0", 64'h100, 32'h13);
        chk("hold0.ev1", 64'(axis.tdata[13:7]), 64'd1);
        commit(64'h100, 32'h13);
        chk("hold.repeat", 64'(axis.tvalid), 64'd0);
        commit(64'h104, 32'h13);
        n_beat++;
        chk_pkt("hold1", 64'h104, 32'h13);
        chk("hold1.ev1", 64'(axis.tdata[13:7]), 64'd3);
        chk("hold1.ev7", 64'(axis.tdata[55:49]), 64'd3);
        chk("hold1.ev0", 64'(axis.tdata[6:0]), 64'd0);
        chk("hold1.ev2", 64'(axis.tdata[20:14]), 64'd0);
        ev = '0;

        commit(64'h108, 32'h10500073);
        chk("wfi.drop", 64'(axis.tvalid), 64'd0);
        commit(64'h10C, 32'h13);
        n_beat++;
        chk_pkt("afterwfi", 64'h10C, 32'h13);
        chk("afterwfi.cycle", axis.tdata[932:869], 64'd8);
        chk("afterwfi.ev1",   64'(axis.tdata[13:7]), 64'd1);

        pc = 64'h200;
        while (n_beat < 201) begin
            commit(pc + 64'd4, 32'h33);
            n_beat++;
            chk("burst.valid", 64'(axis.tvalid), 64'd1);
            chk($sformatf("burst.tlast%0d", n_beat), 64'(axis.tlast), 64'((n_beat % 100) == 0));
        end

        commit(64'h1000, 32'h13);
        chk_pkt("stall.load", 64'h1000, 32'h13);
        axis.tready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            commit(64'h1004 + 64'(4 * j), 32'h13);
            chk_pkt("stall.hold", 64'h1000, 32'h13);
            chk("stall.tlast", 64'(axis.tlast), 64'd0);
        end
        axis.tready = 1'b1;
        commit(64'h2000, 32'h17);
        chk_pkt("stall.b2b", 64'h2000, 32'h17);

        pc_valid = 1'b0;
        ctrl_write(8'd2, 64'h40);
        ctrl_addr = 8'd0; ctrl_wdata = 64'd1; ctrl_we = 1'b1;
        step();
        // strobe stays high: a second write of start address must not happen
        ctrl_addr = 8'd2; ctrl_wdata = 64'h80;
        step();
        step();
        ctrl_we = 1'b0;
        step();
        for (int j = 0; j < 4; j++) begin
            commit(64'h30 + 64'(4 * j), 32'h13);
            chk("pre_start.idle", 64'(axis.tvalid), 64'd0);
        end
        commit(64'h40, 32'h93);
        chk_pkt("start", 64'h40, 32'h93);
        commit(64'h44, 32'h93);
        chk_pkt("start.next", 64'h44, 32'h93);

        pc_valid = 1'b0;
        ctrl_write(8'd3, 64'h60);
        ctrl_write(8'd1, 64'd1);
        for (int j = 0; j < 6; j++) begin
            commit(64'h48 + 64'(4 * j), 32'h13);
            chk_pkt("run", 64'h48 + 64'(4 * j), 32'h13);
        end
        commit(64'h60, 32'hB3);
        chk_pkt("end", 64'h60, 32'hB3);
        commit(64'h64, 32'h13);
        chk("end.after0", 64'(axis.tvalid), 64'd0);
        commit(64'h68, 32'h13);
        chk("end.after1", 64'(axis.tvalid), 64'd0);

        ev[0] = 1'b1;
        for (int j = 0; j < 200; j++) commit(64'h68, 32'h13);
        chk("sat.idle", 64'(axis.tvalid), 64'd0);
        commit(64'h40, 32'h13);
        chk_pkt("sat", 64'h40, 32'h13);
        chk("sat.ev0", 64'(axis.tdata[6:0]), 64'd127);
        chk("sat.ev1", 64'(axis.tdata[13:7]), 64'd0);
        commit(64'h44, 32'h13);
        chk("sat.reload", 64'(axis.tdata[6:0]), 64'd2);
        ev = '0;

        en = 1'b0;
        commit(64'h48, 32'h13);
        chk("en_low.drop", 64'(axis.tvalid), 64'd0);
        en = 1'b1;

        axis.tready = 1'b0;
        commit(64'h4C, 32'h13);
        chk_pkt("pend", 64'h4C, 32'h13);
        rst = 1'b1;
        pc_valid = 1'b0;
        step();
        chk("midrst.tvalid", 64'(axis.tvalid), 64'd0);
        chk("midrst.tdata",  axis.tdata[868:805], 64'd0);
        rst = 1'b0;
        axis.tready = 1'b1;
        commit(64'h4C, 32'h13);
        chk_pkt("postrst", 64'h4C, 32'h13);
        chk("postrst.cycle", axis.tdata[932:869], 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/continuous_monitoring_sys.md
Name: continuous_monitoring_sys

Overview:
Non-intrusive trace monitor attached to a RISC-V core's commit interface. It packs each newly committed instruction into one wide AXI-Stream word and sends it to a downstream FIFO/DMA. Each word carries the PC, the instruction, a cycle timestamp and per-event performance counts accumulated since the previous packet. A small write-only control port configures start/stop address triggers.

Parameters:
XLEN, 64, PC width
AXI_DATA_WIDTH, 1024, stream data width (must be ≥ 965)
NUM_EVENTS, 115, performance event bitmap width
EVENT_COUNTER_WIDTH, 7, per-event counter width
CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED, 1, 1 = write only on rising edge of ctrl_write_enable; 0 = write every cycle it is high

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
instr  in  32  committed instruction
pc  in  XLEN  committed PC
pc_valid  in  1  pc/instr valid this cycle
performance_events  in  NUM_EVENTS  event bitmap, bit i = event i occurred this cycle
en  in  1  global monitor enable
ctrl_addr  in  8  control register address
ctrl_wdata  in  64  control write data
ctrl_write_enable  in  1  control write strobe
tlast_interval  in  32  items per stream burst
M_AXIS_tvalid  out  1  stream valid
M_AXIS_tready  in  1  stream ready
M_AXIS_tdata  out  AXI_DATA_WIDTH  packet
M_AXIS_tlast  out  1  last item of burst

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high.
- Control map, 64-bit registers, all 0 at reset:
  - 0 = TRIGGER_TRACE_START_ADDRESS_ENABLED (bit0)
  - 1 = TRIGGER_TRACE_END_ADDRESS_ENABLED (bit0)
  - 2 = TRIGGER_TRACE_START_ADDRESS
  - 3 = TRIGGER_TRACE_END_ADDRESS
  - Other addresses are ignored.
  - In posedge mode, a write takes effect on the cycle ctrl_write_enable is 1 and its registered previous value is 0.
- Trace state:
  - After reset, tracing is active if the start trigger is disabled, inactive if it is enabled.
  - Enabling the start trigger while active sets tracing inactive.
  - Start trigger: pc_valid && pc == start addr sets tracing active; that instruction is traced.
  - End trigger: pc_valid && pc == end addr emits that packet, then sets tracing inactive.
- New-instruction detection: capture when en && tracing && pc_valid && (pc != last_pc || first valid pc since reset) && instr != 32'h10500073 (WFI is never traced).
  - last_pc updates on every pc_valid cycle, regardless of tracing.
- Event counters, one per event, EVENT_COUNTER_WIDTH bits:
  - Increment when en && event bit is set; saturate at all-ones.
  - On capture, the packet takes count-plus-this-cycle, and the counter reloads to this cycle's bit (0 or 1 → count restarts).
  - If a capture is dropped, counters are not cleared.
- Cycle counter: 64-bit, counts every cycle after reset (en-independent). The value is sampled at capture.
- Packet layout (LSB first):
  - [NUM_EVENTS*7-1:0] = counters, event i at [7i+6:7i]
  - [868:805] = pc
  - [932:869] = cycle counter
  - [964:933] = instr
  - Remaining bits = 0.
- Output register:
  - A capture loads tdata and sets tvalid on the next edge, so a packet is visible 1 cycle after the commit cycle.
  - The slot is free if !tvalid || tready.
  - While tvalid && !tready, tdata/tlast hold stable and new captures are dropped.
  - tvalid clears after acceptance if there is no simultaneous capture.
  - Capture and acceptance in the same cycle is back-to-back: tvalid stays 1 with the new data.
- tlast: an item counter increments on each accepted beat.
  - tlast is driven with the loaded item when item_count == tlast_interval-1; the counter wraps to 0 after that beat is accepted.
  - tlast_interval 0 or 1 gives tlast on every item.
- en low: no captures, counters frozen; a pending output still drains.
- Reset values: tvalid=0, tdata=0, tlast=0, counters=0, cycle counter=0, item count=0, first-pc flag set.
- Reset mid-transfer discards the pending packet.

Test Plan:
- Reset, then pc stepping 4 per cycle with pc_valid=1, tready=1: one packet per cycle, tdata[868:805] = each pc, tdata[964:933] = that cycle's instr, 1-cycle latency.
- pc held constant for 2 cycles: no packet on the repeated cycles; the next packet's event counts include the held cycles (events 8'b10101010 → counters 1,3,5,7 = 3, others 0).
- instr 32'h10500073 at a new pc: no packet; the next packet's cycle-counter delta exceeds 1.
- tlast_interval=100: tlast high on beats 100, 200, … only; tready low 3 cycles → tdata stable and captures dropped.
- Write start addr 0x40 and start-enable=1 (posedge strobe): no packets until pc=0x40, then tracing. Holding the strobe high does not repeat the write.
- End trigger at 0x60: the packet for 0x60 is emitted, none after. Event bit held 200 cycles with pc constant → counter saturates at 127.
